tcd_engine: RTL and testbench
=============================

TCD_ENGINE -- requirements
Module: tcd_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory and flit word width.
REQ-003 SHALL have parameter NB_W, default 16, byte-count width.
REQ-004 SHALL have ports, in order:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- addr_in  in  ADDR_W  request start address.
- nbytes_in  in  NB_W  request length in bytes.
- req_in  in  1  request strobe from MMIO.
- ack_in  in  1  MMIO acknowledge of completion.
- busy_out  out  1  transfer in progress.
- done_out  out  1  transfer complete, awaiting ack_in.
- mem_en_out  out  1  memory read enable.
- mem_addr_out  out  ADDR_W  memory word address.
- mem_data_in  in  DATA_W  memory read data, valid one cycle after mem_en_out.
- flit_valid_out  out  1  output flit valid.
- flit_data_out  out  DATA_W  output flit payload.
- flit_last_out  out  1  marks final flit of transfer.
- flit_ready_in  in  1  downstream accepts flit.

Function
REQ-005 SHALL implement states IDLE, FETCH, WAIT, SEND, DONE (plus CSUM when configured).
REQ-006 IDLE: req_in=1 SHALL latch addr_in with bits [1:0] forced to 0, and latch words = ceil(nbytes_in/4); next state FETCH, or DONE if nbytes_in=0.
REQ-007 busy_out SHALL be 1 in every state except IDLE and DONE; done_out SHALL be 1 only in DONE.
REQ-008 FETCH SHALL assert mem_en_out for exactly one cycle with mem_addr_out = current address; next state WAIT.
REQ-009 WAIT SHALL capture mem_data_in into the flit register; next state SEND.
REQ-010 SEND SHALL hold flit_valid_out, flit_data_out, and flit_last_out stable until flit_ready_in=1.
REQ-011 On a SEND handshake, the block SHALL decrement the remaining-word count and add 4 to the address, modulo 2^ADDR_W (wrap allowed); next state FETCH if words remain, else DONE (or CSUM).
REQ-012 flit_last_out SHALL be 1 only on the final flit of the transfer.
REQ-013 DONE: ack_in=1 SHALL return the block to IDLE next cycle; done_out SHALL stay high until then.
REQ-014 req_in outside IDLE and ack_in outside DONE SHALL be ignored; a request arriving with ack_in in the same cycle SHALL NOT be accepted until IDLE.
REQ-015 Minimum latency SHALL be 3 cycles per word with flit_ready_in held at 1; a nbytes_in=0 request SHALL reach DONE one cycle after acceptance with no flits.
REQ-016 A partial final word SHALL be sent as the full memory word; trailing bytes are unmasked.

Reset
REQ-017 reset SHALL force state IDLE and drive all outputs to 0, including address and data outputs.
REQ-018 reset during any state SHALL abort the transfer with no further flits and no done_out.

Configuration
REQ-019 With TCD_CHECKSUM_EN defined, the block SHALL keep a DATA_W-bit XOR of every payload flit sent; after the last payload flit it SHALL enter CSUM and send one extra flit carrying the XOR with flit_last_out=1; the payload's last flit then SHALL have flit_last_out=0.
REQ-020 Without TCD_CHECKSUM_EN, the block SHALL have no CSUM state and no extra flit; a nbytes_in=0 request SHALL send no flit in either configuration.

Structure
REQ-021 The shared package tcd_pkg SHALL hold the state enum, the default widths, and the WORD_BYTES=4 constant.
REQ-022 The block SHALL be a single module with no sub-module; the flit register is inline.

Verification
REQ-023 addr_in=0x100, nbytes_in=8, ready held 1 -> reads at 0x100 and 0x104; 2 flits; last on 2nd; done_out high 7 cycles after request; ack_in -> IDLE.
REQ-024 nbytes_in=5 -> 2 words read; nbytes_in=0 -> no mem_en_out, no flit, done_out next cycle.
REQ-025 flit_ready_in low 4 cycles during SEND -> flit held stable, no extra mem_en_out, no data loss.
REQ-026 addr_in=0xFFFFFFFC, nbytes_in=8 -> reads at 0xFFFFFFFC then 0x00000000.
REQ-027 reset asserted in SEND of word 2 of 4 -> all outputs 0 next cycle; a new request afterwards completes normally.
REQ-028 TCD_CHECKSUM_EN, data 0x0F0F0F0F and 0xFF00FF00 -> third flit 0xF00FF00F with last=1; second flit last=0.

Source files
------------

// File: rtl/tcd_pkg.sv
// Shared types and constants for the TCD transfer engine.
// TCD_CHECKSUM_EN adds the CSUM state used for the trailing XOR flit.
package tcd_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NB_W_DEF   = 16;
  localparam int WORD_BYTES = 4;

`ifdef TCD_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4,
    ST_CSUM  = 3'd5
  } tcd_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } tcd_state_e;
`endif

endpackage

// File: rtl/tcd_engine.sv
// Word-at-a-time memory-to-flit transfer engine driven by an MMIO request/ack pair.
// Define TCD_CHECKSUM_EN to append an XOR checksum flit after the payload.
module tcd_engine
  import tcd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NB_W   = NB_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [NB_W-1:0]   nbytes_in,
  input  logic              req_in,
  input  logic              ack_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              mem_en_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              flit_valid_out,
  output logic [DATA_W-1:0] flit_data_out,
  output logic              flit_last_out,
  input  logic              flit_ready_in
);

  localparam int WORDS_W = NB_W - 1;

  tcd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WORDS_W-1:0] words_q;
  logic [DATA_W-1:0] flit_q;
  logic [NB_W:0]     nb_round;
  logic [WORDS_W-1:0] req_words;
  logic              send_fire;
  logic              last_word;
`ifdef TCD_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  // Round the byte count up to whole words; partial trailing words go out unmasked.
  assign nb_round  = {1'b0, nbytes_in} + (NB_W+1)'(WORD_BYTES - 1);
  assign req_words = WORDS_W'(nb_round >> 2);
  assign last_word = (words_q == WORDS_W'(1));

  // Flit handshake: a flit transfers on a rising edge where flit_valid_out and
  // flit_ready_in are both 1; valid, data and last hold steady until then.
  assign send_fire = (state_q == ST_SEND) && flit_ready_in;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_in) state_d = (nbytes_in == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_SEND;
      ST_SEND: begin
        if (flit_ready_in) begin
          if (!last_word) begin
            state_d = ST_FETCH;
          end else begin
`ifdef TCD_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef TCD_CHECKSUM_EN
      ST_CSUM:  if (flit_ready_in) state_d = ST_DONE;
`endif
      ST_DONE:  if (ack_in) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      words_q <= '0;
      flit_q  <= '0;
`ifdef TCD_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_in) begin
        addr_q  <= addr_in & ~ADDR_W'(WORD_BYTES - 1);
        words_q <= req_words;
`ifdef TCD_CHECKSUM_EN
        csum_q  <= '0;
`endif
      end
      if (state_q == ST_WAIT) begin
        flit_q <= mem_data_in;
      end
      if (send_fire) begin
        words_q <= words_q - WORDS_W'(1);
        addr_q  <= addr_q + ADDR_W'(WORD_BYTES);
`ifdef TCD_CHECKSUM_EN
        csum_q  <= csum_q ^ flit_q;
        // The checksum flit reuses the flit register so the output path stays single-sourced.
        if (last_word) flit_q <= csum_q ^ flit_q;
`endif
      end
    end
  end

  always_comb begin
    busy_out       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done_out       = (state_q == ST_DONE);
    mem_en_out     = (state_q == ST_FETCH);
    mem_addr_out   = addr_q;
    flit_data_out  = flit_q;
`ifdef TCD_CHECKSUM_EN
    flit_valid_out = (state_q == ST_SEND) || (state_q == ST_CSUM);
    flit_last_out  = (state_q == ST_CSUM);
`else
    flit_valid_out = (state_q == ST_SEND);
    flit_last_out  = (state_q == ST_SEND) && last_word;
`endif
  end

endmodule

// File: tb/tb_tcd_engine.sv
// Self-checking bench for tcd_engine: memory responder, scoreboard of reads and flits.
// Honours TCD_CHECKSUM_EN when building expectations.
module tb_tcd_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_in = '0;
  logic [15:0] nbytes_in = '0;
  logic        req_in = 1'b0;
  logic        ack_in = 1'b0;
  logic        busy_out, done_out, mem_en_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_in = '0;
  logic        flit_valid_out;
  logic [31:0] flit_data_out;
  logic        flit_last_out;
  logic        flit_ready_in = 1'b1;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int ready_mode = 0;      // 0: held 1, 1: random, 2: ready_val
  logic ready_val = 1'b1;

  logic [31:0] exp_addr_q[$];
  logic [32:0] exp_q[$];   // {last, data}
  logic [31:0] mem_ovr [logic [31:0]];
  logic [31:0] mon_ea;
  logic [32:0] mon_ef;

  tcd_engine dut (
    .clock          (clock),
    .reset          (reset),
    .addr_in        (addr_in),
    .nbytes_in      (nbytes_in),
    .req_in         (req_in),
    .ack_in         (ack_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .mem_en_out     (mem_en_out),
    .mem_addr_out   (mem_addr_out),
    .mem_data_in    (mem_data_in),
    .flit_valid_out (flit_valid_out),
    .flit_data_out  (flit_data_out),
    .flit_last_out  (flit_last_out),
    .flit_ready_in  (flit_ready_in)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0] ^ 16'h3C5A, a[31:16] ^ 16'hA5C3};
  endfunction

  // Memory responds one cycle after the enable; otherwise a poison value.
  always @(posedge clock) begin
    if (mem_en_out === 1'b1) mem_data_in <= mem_word(mem_addr_out);
    else                     mem_data_in <= 32'hDEAD_BEEF;
  end

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       flit_ready_in = 1'b1;
      1:       flit_ready_in = 1'($urandom_range(0, 1));
      default: flit_ready_in = ready_val;
    endcase
  end

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      if (mem_en_out === 1'b1) begin
        total++;
        if (exp_addr_q.size() == 0) begin
          $display("FAIL mem_read: unexpected read at %h, required no read", mem_addr_out);
        end else begin
          mon_ea = exp_addr_q.pop_front();
          if (mem_addr_out !== mon_ea)
            $display("FAIL mem_read: addr %h, required %h", mem_addr_out, mon_ea);
          else passed++;
        end
      end
      if (flit_valid_out === 1'b1 && flit_ready_in === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL flit: unexpected flit %h last=%b, required no flit",
                   flit_data_out, flit_last_out);
        end else begin
          mon_ef = exp_q.pop_front();
          if ({flit_last_out, flit_data_out} !== mon_ef)
            $display("FAIL flit: data %h last %b, required data %h last %b",
                     flit_data_out, flit_last_out, mon_ef[31:0], mon_ef[32]);
          else passed++;
        end
      end
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic int words_of(input int nbytes);
    return (nbytes + 3) / 4;
  endfunction

  function automatic int exp_latency(input int nbytes);
    int w = words_of(nbytes);
    int lat = 3 * w + 1;
`ifdef TCD_CHECKSUM_EN
    if (w > 0) lat = lat + 1;
`endif
    return lat;
  endfunction

  task automatic push_expect(input logic [31:0] addr, input int nbytes);
    logic [31:0] a = addr & ~32'd3;
    logic [31:0] x = '0;
    logic [31:0] d;
    logic        last;
    int w = words_of(nbytes);
    for (int i = 0; i < w; i++) begin
      exp_addr_q.push_back(a);
      d = mem_word(a);
      x = x ^ d;
      last = (i == w - 1);
`ifdef TCD_CHECKSUM_EN
      last = 1'b0;
`endif
      exp_q.push_back({last, d});
      a = a + 32'd4;
    end
`ifdef TCD_CHECKSUM_EN
    if (w > 0) exp_q.push_back({1'b1, x});
`endif
  endtask

  task automatic start_xfer(input logic [31:0] addr, input int nbytes, output int c_acc);
    push_expect(addr, nbytes);
    addr_in   = addr;
    nbytes_in = 16'(nbytes);
    req_in    = 1'b1;
    cycle();
    c_acc     = cyc;
    req_in    = 1'b0;
    addr_in   = $urandom;
    nbytes_in = 16'($urandom);
    total++;
    if ({busy_out, done_out} !== {words_of(nbytes) > 0, words_of(nbytes) == 0})
      $display("FAIL accept: busy/done %b%b, required %b%b", busy_out, done_out,
               words_of(nbytes) > 0, words_of(nbytes) == 0);
    else passed++;
  endtask

  task automatic finish_xfer(input int c_acc, input int exp_lat);
    while (done_out !== 1'b1 && (cyc - c_acc) < 3000) cycle();
    total++;
    if (done_out !== 1'b1) begin
      $display("FAIL done_wait: done_out %b after %0d cycles, required 1", done_out, cyc - c_acc);
      return;
    end
    passed++;
    if (exp_lat >= 0) begin
      total++;
      if (cyc - c_acc + 1 !== exp_lat)
        $display("FAIL latency: done after %0d cycles, required %0d", cyc - c_acc + 1, exp_lat);
      else passed++;
    end
    cycle();
    total++;
    if ({done_out, busy_out} !== 2'b10)
      $display("FAIL done_hold: done/busy %b%b, required 10", done_out, busy_out);
    else passed++;
    ack_in    = 1'b1;
    req_in    = 1'b1;
    addr_in   = 32'h900;
    nbytes_in = 16'd4;
    cycle();
    ack_in = 1'b0;
    total++;
    if ({done_out, busy_out} !== 2'b00)
      $display("FAIL ack_idle: done/busy %b%b, required 00", done_out, busy_out);
    else passed++;
    req_in = 1'b0;
    cycle();
    total++;
    if ({done_out, busy_out, mem_en_out} !== 3'b000)
      $display("FAIL req_during_ack: done/busy/mem_en %b%b%b, required 000",
               done_out, busy_out, mem_en_out);
    else passed++;
    total++;
    if (exp_addr_q.size() != 0 || exp_q.size() != 0)
      $display("FAIL drain: %0d reads and %0d flits outstanding, required 0 and 0",
               exp_addr_q.size(), exp_q.size());
    else passed++;
  endtask

  task automatic run_xfer(input logic [31:0] addr, input int nbytes, input bit check_lat);
    int c_acc;
    start_xfer(addr, nbytes, c_acc);
    finish_xfer(c_acc, check_lat ? exp_latency(nbytes) : -1);
  endtask

  task automatic check_outputs_zero(input string tag);
    total++;
    if ({busy_out, done_out, mem_en_out, flit_valid_out, flit_last_out} !== 5'b0 ||
        mem_addr_out !== 32'h0 || flit_data_out !== 32'h0)
      $display("FAIL %s: busy %b done %b mem_en %b addr %h valid %b data %h last %b, required all 0",
               tag, busy_out, done_out, mem_en_out, mem_addr_out, flit_valid_out,
               flit_data_out, flit_last_out);
    else passed++;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    check_outputs_zero("reset_state");
    reset = 1'b0;
    cycle();
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    ready_mode = 0;
    run_xfer(32'h100, 8, 1'b1);
  endtask

  task automatic test_partial_and_zero();
    run_xfer(32'h203, 5, 1'b1);
    run_xfer(32'h300, 0, 1'b1);
    run_xfer(32'h40, 1, 1'b1);
  endtask

  task automatic test_wrap();
    run_xfer(32'hFFFF_FFFC, 8, 1'b1);
  endtask

  task automatic test_stall();
    int c_acc;
    int n = 0;
    ready_val  = 1'b0;
    ready_mode = 2;
    cycle();
    start_xfer(32'h400, 12, c_acc);
    while (flit_valid_out !== 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (flit_valid_out !== 1'b1 || mem_en_out !== 1'b0 || exp_q.size() == 0 ||
          {flit_last_out, flit_data_out} !== exp_q[0])
        $display("FAIL stall_hold: valid %b mem_en %b data %h last %b, required 1 0 %h %b",
                 flit_valid_out, mem_en_out, flit_data_out, flit_last_out,
                 exp_q.size() ? exp_q[0][31:0] : 32'h0, exp_q.size() ? exp_q[0][32] : 1'b0);
      else passed++;
      cycle();
    end
    ready_val = 1'b1;
    finish_xfer(c_acc, -1);
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    int c_acc;
    int n = 0;
    ready_mode = 0;
    start_xfer(32'h500, 16, c_acc);
    while (!(flit_valid_out === 1'b1 && exp_q.size() == 3) && n < 50) begin
      cycle();
      n++;
    end
    total++;
    if (flit_valid_out !== 1'b1)
      $display("FAIL reset_mid_reach: valid %b, required 1 in second SEND", flit_valid_out);
    else passed++;
    reset = 1'b1;
    cycle();
    check_outputs_zero("reset_mid_abort");
    exp_q.delete();
    exp_addr_q.delete();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if ({done_out, busy_out} !== 2'b00)
        $display("FAIL post_abort: done/busy %b%b, required 00", done_out, busy_out);
      else passed++;
    end
    run_xfer(32'h600, 8, 1'b1);
  endtask

  task automatic test_checksum();
    mem_ovr[32'h700] = 32'h0F0F_0F0F;
    mem_ovr[32'h704] = 32'hFF00_FF00;
    run_xfer(32'h700, 8, 1'b1);
  endtask

  task automatic test_random();
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      run_xfer($urandom, $urandom_range(0, 40), 1'b0);
    end
    ready_mode = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) run_xfer(32'h800 + 32'(i * 64), 4 * (i + 1), 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_and_zero();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_checksum();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
